// File: rtl/chunked_add_sub_comp.sv
// chunked_add_sub_comp
//
// Multi-cycle add / subtract / compare unit. The operands are NUM_SIZE bits
// wide and are processed CHUNK_SIZE bits per clock. A single chunk adder and
// a registered carry do the work, which keeps this unit small enough to act
// as a narrow arithmetic or branch-compare resource in the RV32I execute path.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   nRst         asynchronous active-low reset
//   inValid      request valid (only looked at in IDLE)
//   inReady      unit can accept; high only in IDLE
//   op           00 ADD, 01 SUB, 10 CMPS (signed), 11 CMPU (unsigned)
//   dIn0, dIn1   operands; latched when the request is accepted
//   outValid     result and flags valid; high only in DONE
//   outReady     consumer accepts the result
//   result       dIn0 + dIn1 for ADD, dIn0 - dIn1 for every other op
//   carryOut     final carry; for non-ADD ops, 1 means no borrow
//   overflow     signed overflow of the performed operation
//   equal, lessThan, greaterThan
//                compare flags for dIn0 vs dIn1; all 0 for ADD
module chunked_add_sub_comp #(
  parameter int NUM_SIZE   = 32,
  parameter int CHUNK_SIZE = 8
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic                inValid,
  output logic                inReady,
  input  logic [1:0]          op,
  input  logic [NUM_SIZE-1:0] dIn0,
  input  logic [NUM_SIZE-1:0] dIn1,
  output logic                outValid,
  input  logic                outReady,
  output logic [NUM_SIZE-1:0] result,
  output logic                carryOut,
  output logic                overflow,
  output logic                equal,
  output logic                lessThan,
  output logic                greaterThan
);

  localparam int NUM_CHUNKS = NUM_SIZE / CHUNK_SIZE;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMPU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic [1:0]           op_q, op_d;
  logic [NUM_SIZE-1:0]  a_q, a_d;
  logic [NUM_SIZE-1:0]  b_q, b_d;
  logic [NUM_SIZE-1:0]  result_q, result_d;
  logic                 carry_out_q, carry_out_d;
  logic                 overflow_q, overflow_d;
  logic                 equal_q, equal_d;
  logic                 less_q, less_d;
  logic                 greater_q, greater_d;

  logic                  inv;
  logic [CHUNK_SIZE-1:0] a_chunk;
  logic [CHUNK_SIZE-1:0] b_chunk;
  logic [CHUNK_SIZE-1:0] b_inv;
  logic [CHUNK_SIZE:0]   sum;
  logic                  last_chunk;
  logic                  cin_msb;
  logic                  ovf_calc;
  logic                  zero_all;
  logic                  lt_calc;

  // Shared chunk adder. Subtraction is a + ~b + 1, and the +1 is the
  // initial carry that is loaded at acceptance. The chunk is picked with
  // constant slices so the mux stays simple and lint-clean.
  always_comb begin
    inv     = (op_q != OP_ADD);
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        a_chunk = a_q[k*CHUNK_SIZE +: CHUNK_SIZE];
        b_chunk = b_q[k*CHUNK_SIZE +: CHUNK_SIZE];
      end
    end
    b_inv      = b_chunk ^ {CHUNK_SIZE{inv}};
    sum        = {1'b0, a_chunk} + {1'b0, b_inv} + {{CHUNK_SIZE{1'b0}}, carry_q};
    last_chunk = (idx_q == LAST_IDX);
    // The carry into the MSB is recovered from the sum bit of the top
    // position. This only means something on the last chunk.
    cin_msb    = a_chunk[CHUNK_SIZE-1] ^ b_inv[CHUNK_SIZE-1] ^ sum[CHUNK_SIZE-1];
    ovf_calc   = cin_msb ^ sum[CHUNK_SIZE];
    zero_all   = zero_q & (sum[CHUNK_SIZE-1:0] == '0);
    lt_calc    = (op_q == OP_CMPU) ? ~sum[CHUNK_SIZE] : (sum[CHUNK_SIZE-1] ^ ovf_calc);
  end

  // Next-state logic. The partial sums overwrite the consumed chunks of a_q,
  // so no separate accumulator is needed. The visible result and flags only
  // change on the last chunk, which keeps them holding their old values
  // through IDLE and RUN.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    equal_d     = equal_q;
    less_d      = less_q;
    greater_d   = greater_q;

    unique case (state_q)
      S_IDLE: begin
        if (inValid) begin
          a_d     = dIn0;
          b_d     = dIn1;
          op_d    = op;
          idx_d   = '0;
          carry_d = (op != OP_ADD);
          zero_d  = 1'b1;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        for (int k = 0; k < NUM_CHUNKS; k++) begin
          if (idx_q == IDX_W'(k)) begin
            a_d[k*CHUNK_SIZE +: CHUNK_SIZE] = sum[CHUNK_SIZE-1:0];
          end
        end
        carry_d = sum[CHUNK_SIZE];
        zero_d  = zero_all;
        if (last_chunk) begin
          result_d    = a_d;
          carry_out_d = sum[CHUNK_SIZE];
          overflow_d  = ovf_calc;
          equal_d     = inv & zero_all;
          less_d      = inv & lt_calc;
          greater_d   = inv & ~lt_calc & ~zero_all;
          idx_d       = '0;
          state_d     = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_DONE: begin
        if (outReady) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers. An asynchronous reset aborts any
  // operation that is in flight and clears every visible output.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      equal_q     <= 1'b0;
      less_q      <= 1'b0;
      greater_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      equal_q     <= equal_d;
      less_q      <= less_d;
      greater_q   <= greater_d;
    end
  end

  // The handshake outputs are decoded from the state register alone.
  assign inReady     = (state_q == S_IDLE);
  assign outValid    = (state_q == S_DONE);
  assign result      = result_q;
  assign carryOut    = carry_out_q;
  assign overflow    = overflow_q;
  assign equal       = equal_q;
  assign lessThan    = less_q;
  assign greaterThan = greater_q;

endmodule

// File: tb/tb_chunked_add_sub_comp.sv
// tb_chunked_add_sub_comp
//
// Bench for chunked_add_sub_comp. It drives directed vectors into a 32/8
// instance and a 32/32 instance. A full-width arithmetic model and a
// cycle timeline of the handshake give the expected outputs. One process
// compares the main instance against them on every falling edge.
module tb_chunked_add_sub_comp;

  localparam int NS = 32;
  localparam int CS = 8;
  localparam int NC = NS / CS;

  localparam logic [1:0] ADD  = 2'b00;
  localparam logic [1:0] SUB  = 2'b01;
  localparam logic [1:0] CMPS = 2'b10;
  localparam logic [1:0] CMPU = 2'b11;

  logic          clk = 1'b0;
  logic          nRst = 1'b1;
  logic          inValid = 1'b0;
  logic          inReady;
  logic [1:0]    op = 2'b00;
  logic [NS-1:0] dIn0 = '0;
  logic [NS-1:0] dIn1 = '0;
  logic          outValid;
  logic          outReady = 1'b1;
  logic [NS-1:0] result;
  logic          carryOut, overflow, equal, lessThan, greaterThan;

  logic          inValid2 = 1'b0;
  logic          inReady2;
  logic [1:0]    op2 = 2'b00;
  logic [NS-1:0] dIn0_2 = '0;
  logic [NS-1:0] dIn1_2 = '0;
  logic          outValid2;
  logic          outReady2 = 1'b1;
  logic [NS-1:0] result2;
  logic          carryOut2, overflow2, equal2, lessThan2, greaterThan2;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Expected visible state of the main instance.
  logic          exp_ready = 1'b1;
  logic          exp_valid = 1'b0;
  logic [NS-1:0] exp_result = '0;
  logic          exp_carry = 1'b0, exp_ovf = 1'b0, exp_eq = 1'b0, exp_lt = 1'b0, exp_gt = 1'b0;

  // Model output for the request that is currently in flight.
  logic [NS-1:0] pend_result;
  logic          pend_carry, pend_ovf, pend_eq, pend_lt, pend_gt;

  chunked_add_sub_comp #(.NUM_SIZE(NS), .CHUNK_SIZE(CS)) dut (
    .clk(clk), .nRst(nRst), .inValid(inValid), .inReady(inReady), .op(op),
    .dIn0(dIn0), .dIn1(dIn1), .outValid(outValid), .outReady(outReady),
    .result(result), .carryOut(carryOut), .overflow(overflow), .equal(equal),
    .lessThan(lessThan), .greaterThan(greaterThan)
  );

  chunked_add_sub_comp #(.NUM_SIZE(NS), .CHUNK_SIZE(NS)) dut_wide (
    .clk(clk), .nRst(nRst), .inValid(inValid2), .inReady(inReady2), .op(op2),
    .dIn0(dIn0_2), .dIn1(dIn1_2), .outValid(outValid2), .outReady(outReady2),
    .result(result2), .carryOut(carryOut2), .overflow(overflow2), .equal(equal2),
    .lessThan(lessThan2), .greaterThan(greaterThan2)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [NS-1:0] act, input logic [NS-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_flag(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from plain full-width arithmetic.
  task automatic model_op(input logic [1:0] o, input logic [NS-1:0] a, input logic [NS-1:0] b);
    logic [NS:0] full;
    if (o == ADD) begin
      full        = {1'b0, a} + {1'b0, b};
      pend_result = full[NS-1:0];
      pend_carry  = full[NS];
      pend_ovf    = (a[NS-1] == b[NS-1]) && (full[NS-1] != a[NS-1]);
      pend_eq     = 1'b0;
      pend_lt     = 1'b0;
      pend_gt     = 1'b0;
    end else begin
      pend_result = a - b;
      pend_carry  = (a >= b);
      pend_ovf    = (a[NS-1] != b[NS-1]) && (pend_result[NS-1] != a[NS-1]);
      pend_eq     = (a == b);
      pend_lt     = (o == CMPU) ? (a < b) : ($signed(a) < $signed(b));
      pend_gt     = !pend_lt && !pend_eq;
    end
  endtask

  task automatic clear_expect();
    exp_result = '0;
    exp_carry  = 1'b0;
    exp_ovf    = 1'b0;
    exp_eq     = 1'b0;
    exp_lt     = 1'b0;
    exp_gt     = 1'b0;
    exp_valid  = 1'b0;
    exp_ready  = 1'b1;
  endtask

  // This is called 1 time unit after the accepting edge. During RUN the
  // operand and op inputs are scrambled, and they must have no effect.
  task automatic run_after_accept(input logic [1:0] o, input logic [NS-1:0] a, input logic [NS-1:0] b);
    inValid   = 1'b0;
    exp_ready = 1'b0;
    model_op(o, a, b);
    for (int k = 0; k < NC; k++) begin
      dIn0 = $urandom;
      dIn1 = $urandom;
      op   = 2'($urandom);
      @(posedge clk);
      #1;
    end
    exp_valid  = 1'b1;
    exp_result = pend_result;
    exp_carry  = pend_carry;
    exp_ovf    = pend_ovf;
    exp_eq     = pend_eq;
    exp_lt     = pend_lt;
    exp_gt     = pend_gt;
    if (outReady) begin
      @(posedge clk);
      #1;
      exp_valid = 1'b0;
      exp_ready = 1'b1;
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] o, input logic [NS-1:0] a, input logic [NS-1:0] b);
    @(negedge clk);
    op      = o;
    dIn0    = a;
    dIn1    = b;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    run_after_accept(o, a, b);
  endtask

  // Per-cycle comparison of the main instance against the expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      check_flag("inReady", inReady, exp_ready);
      check_flag("outValid", outValid, exp_valid);
      check_output("result", result, exp_result);
      check_flag("carryOut", carryOut, exp_carry);
      check_flag("overflow", overflow, exp_ovf);
      check_flag("equal", equal, exp_eq);
      check_flag("lessThan", lessThan, exp_lt);
      check_flag("greaterThan", greaterThan, exp_gt);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start");
    #1 nRst = 1'b0;
    clear_expect();
    #1;
    check_output("rst_result", result, 32'h0);
    check_flag("rst_inReady", inReady, 1'b1);
    check_flag("rst_outValid", outValid, 1'b0);
    check_output("rst_result2", result2, 32'h0);
    check_flag("rst_inReady2", inReady2, 1'b1);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    nRst = 1'b1;

    // Signed overflow on ADD, four chunk edges of latency.
    apply_stimulus(ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    check_output("add_ovf_result", result, 32'h8000_0000);
    check_flag("add_ovf_overflow", overflow, 1'b1);
    check_flag("add_ovf_carry", carryOut, 1'b0);

    // Signed compare, then unsigned compare on the same operands.
    apply_stimulus(CMPS, 32'hFFFF_FFFF, 32'h0000_0001);
    check_output("cmps_result", result, 32'hFFFF_FFFE);
    check_flag("cmps_lt", lessThan, 1'b1);
    check_flag("cmps_gt", greaterThan, 1'b0);
    check_flag("cmps_eq", equal, 1'b0);
    apply_stimulus(CMPU, 32'hFFFF_FFFF, 32'h0000_0001);
    check_flag("cmpu_gt", greaterThan, 1'b1);
    check_flag("cmpu_lt", lessThan, 1'b0);
    check_flag("cmpu_carry", carryOut, 1'b1);

    apply_stimulus(SUB, 32'h1234_5678, 32'h1234_5678);
    check_output("sub_eq_result", result, 32'h0);
    check_flag("sub_eq_equal", equal, 1'b1);
    check_flag("sub_eq_carry", carryOut, 1'b1);
    check_flag("sub_eq_overflow", overflow, 1'b0);

    apply_stimulus(SUB, 32'h8000_0000, 32'h0000_0001);
    check_output("sub_ovf_result", result, 32'h7FFF_FFFF);
    check_flag("sub_ovf_overflow", overflow, 1'b1);
    check_flag("sub_ovf_lt", lessThan, 1'b1);

    // With ADD the compare flags stay low even when the sum is zero.
    apply_stimulus(ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    check_output("add_wrap_result", result, 32'h0);
    check_flag("add_wrap_carry", carryOut, 1'b1);
    check_flag("add_wrap_equal", equal, 1'b0);

    apply_stimulus(CMPS, 32'h0000_0005, 32'hFFFF_FFFD);
    check_output("cmps_pos_result", result, 32'h0000_0008);
    check_flag("cmps_pos_gt", greaterThan, 1'b1);

    apply_stimulus(CMPU, 32'h0000_0003, 32'h0000_0003);
    check_flag("cmpu_eq_equal", equal, 1'b1);
    check_flag("cmpu_eq_lt", lessThan, 1'b0);

    // Backpressure: a stall in DONE while a new request waits.
    outReady = 1'b0;
    apply_stimulus(SUB, 32'd100, 32'd250);
    check_output("bp_result", result, 32'hFFFF_FF6A);
    @(negedge clk);
    inValid = 1'b1;
    op      = ADD;
    dIn0    = 32'h1111_1111;
    dIn1    = 32'h2222_2222;
    repeat (5) @(posedge clk);
    @(negedge clk);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    exp_ready = 1'b1;
    check_flag("bp_idle_ready", inReady, 1'b1);
    check_flag("bp_idle_valid", outValid, 1'b0);
    @(posedge clk);
    #1;
    run_after_accept(ADD, 32'h1111_1111, 32'h2222_2222);
    check_output("bp_next_result", result, 32'h3333_3333);

    // A reset after two chunks of a SUB aborts it with no result.
    @(negedge clk);
    op      = SUB;
    dIn0    = 32'h0000_0009;
    dIn1    = 32'h0000_0004;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid   = 1'b0;
    exp_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    clear_expect();
    nRst = 1'b0;
    #1;
    check_output("abort_result", result, 32'h0);
    check_flag("abort_inReady", inReady, 1'b1);
    check_flag("abort_outValid", outValid, 1'b0);
    check_flag("abort_carry", carryOut, 1'b0);
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    repeat (8) @(posedge clk);

    // Single-chunk instance: RUN lasts exactly one cycle.
    @(negedge clk);
    op2      = ADD;
    dIn0_2   = 32'd5;
    dIn1_2   = 32'd3;
    inValid2 = 1'b1;
    @(posedge clk);
    #1;
    inValid2 = 1'b0;
    check_flag("wide_run_valid", outValid2, 1'b0);
    check_flag("wide_run_ready", inReady2, 1'b0);
    @(posedge clk);
    #1;
    check_flag("wide_done_valid", outValid2, 1'b1);
    check_output("wide_result", result2, 32'd8);
    check_flag("wide_carry", carryOut2, 1'b0);
    @(posedge clk);
    #1;
    check_flag("wide_idle_ready", inReady2, 1'b1);
    check_flag("wide_idle_valid", outValid2, 1'b0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
